core_event_arbiter: RTL

- Sits directly upstream of core_monitor.
- Accepts sent-message and received-message events from every core, buffers them per core, and serializes them.
- Output is at most one event per cycle on the single msg / core_id / sent_msg_vld / rcv_msg_vld port that core_monitor consumes.
- Fair round-robin arbitration across cores; no event is dropped or reordered within a core.

---
 rtl/core_event_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/core_event_arbiter.sv
// Per-core event FIFOs feeding a round-robin arbiter that serializes sent/received
// message events to core_monitor. Define CORE_EVENT_ARB_RCV_PRIORITY_EN to favour received-event heads.
module core_event_arbiter #(
    parameter int NUM_CORE   = 4,
    parameter int MSG_WID    = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_CORE    = $clog2(NUM_CORE)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CORE-1:0]          in_vld,
    input  logic [NUM_CORE-1:0]          in_is_rcv,
    input  logic [NUM_CORE*MSG_WID-1:0]  in_msg,
    output logic [NUM_CORE-1:0]          in_rdy,
    output logic [MSG_WID-1:0]           msg,
    output logic [NB_CORE-1:0]           core_id,
    output logic                         sent_msg_vld,
    output logic                         rcv_msg_vld
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = MSG_WID + 1;   // {is_rcv, payload}

    logic [NUM_CORE-1:0]         w_nonempty;
    logic [NUM_CORE-1:0]         w_search;
    logic [NUM_CORE-1:0][EW-1:0] w_head;
    logic                        w_grant_vld;
    logic [NB_CORE-1:0]          w_grant_idx;
    logic [NB_CORE-1:0]          w_cand;
    logic [EW-1:0]               w_grant_head;

    logic [NB_CORE-1:0]          r_rr_ptr;
    logic [MSG_WID-1:0]          r_msg;
    logic [NB_CORE-1:0]          r_core_id;
    logic                        r_sent_vld;
    logic                        r_rcv_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORE; gi++) begin : g_core
            logic [EW-1:0] r_mem [FIFO_DEPTH];
            logic [PW-1:0] r_wr_ptr;
            logic [PW-1:0] r_rd_ptr;
            logic [CW-1:0] r_count;
            logic          w_push;
            logic          w_pop;

            // Ready depends only on the stored count, never on this cycle's pop.
            assign in_rdy[gi]     = (r_count != CW'(FIFO_DEPTH));
            assign w_nonempty[gi] = (r_count != '0);
            assign w_push         = in_vld[gi] && in_rdy[gi];
            assign w_pop          = w_grant_vld && (w_grant_idx == NB_CORE'(gi));
            assign w_head[gi]     = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= {in_is_rcv[gi], in_msg[gi*MSG_WID +: MSG_WID]};
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + PW'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

`ifdef CORE_EVENT_ARB_RCV_PRIORITY_EN
    logic [NUM_CORE-1:0] w_rcv_elig;

    // Received-event heads win whenever any exist; otherwise fall back to all non-empty FIFOs.
    always_comb begin
        w_rcv_elig = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            w_rcv_elig[i] = w_nonempty[i] & w_head[i][EW-1];
        end
        w_search = (|w_rcv_elig) ? w_rcv_elig : w_nonempty;
    end
`else
    assign w_search = w_nonempty;
`endif

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            w_cand = r_rr_ptr + NB_CORE'(k);
            if (!w_grant_vld && w_search[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_grant_head = w_head[w_grant_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_msg      <= '0;
            r_core_id  <= '0;
            r_sent_vld <= 1'b0;
            r_rcv_vld  <= 1'b0;
        end else if (w_grant_vld) begin
            r_rr_ptr   <= w_grant_idx + NB_CORE'(1);
            r_msg      <= w_grant_head[MSG_WID-1:0];
            r_core_id  <= w_grant_idx;
            r_rcv_vld  <= w_grant_head[EW-1];
            r_sent_vld <= !w_grant_head[EW-1];
        end else begin
            r_sent_vld <= 1'b0;
            r_rcv_vld  <= 1'b0;
        end
    end

    assign msg          = r_msg;
    assign core_id      = r_core_id;
    assign sent_msg_vld = r_sent_vld;
    assign rcv_msg_vld  = r_rcv_vld;

endmodule
